// File: rtl/sfx_arbiter.sv
// sfx_arbiter: shares the tone generator between the BGM sequencer and two
// tick-timed sound effects (hit, miss). BGM scale codes pass through while
// idle; a request plays a fixed step list in place of the BGM, then hands back.
// Optional feature macro: SFX_PREEMPT_EN (requests during an effect preempt or
// restart it; when undefined every effect plays to completion).
module sfx_arbiter #(
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] scrnum,
    input  logic [6:0] bgm_scale,
    input  logic       hit_req,
    input  logic       miss_req,
    output logic [6:0] scale,
    output logic       sfx_active
);

    typedef enum logic [1:0] {IDLE, HIT, MISS} state_t;

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_CYCLES - 1);

    // Scale code of each effect step; index 3 is never reached.
    function automatic logic [6:0] step_code(input state_t st, input logic [1:0] idx);
        logic [6:0] code;
        code = 7'd0;
        case (st)
            HIT: begin
                case (idx)
                    2'd0:    code = 7'd36;
                    2'd1:    code = 7'd31;
                    2'd2:    code = 7'd23;
                    default: code = 7'd0;
                endcase
            end
            MISS: begin
                case (idx)
                    2'd0:    code = 7'd82;
                    2'd1:    code = 7'd0;
                    2'd2:    code = 7'd92;
                    default: code = 7'd0;
                endcase
            end
            default: code = 7'd0;
        endcase
        return code;
    endfunction

    // Step duration in ticks minus one (the remaining-ticks reload value).
    function automatic logic [1:0] step_len_m1(input state_t st, input logic [1:0] idx);
        logic [1:0] len;
        len = 2'd0;
        case (st)
            HIT: begin
                case (idx)
                    2'd2:    len = 2'd1;
                    default: len = 2'd0;
                endcase
            end
            MISS: begin
                case (idx)
                    2'd0:    len = 2'd1;
                    2'd2:    len = 2'd2;
                    default: len = 2'd0;
                endcase
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

    state_t          state_reg, state_next;
    logic [1:0]      step_reg, step_next;
    logic [TW-1:0]   tick_reg, tick_next;
    logic [1:0]      rem_reg, rem_next;
    logic [6:0]      scale_reg, scale_next;
    logic            active_reg, active_next;

    logic enabled;
    logic step_end;
    logic last_expiring;
    logic take_idle_req;
    logic start_miss;
    logic start_hit;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_next  = state_reg;
        step_next   = step_reg;
        tick_next   = tick_reg;
        rem_next    = rem_reg;

        enabled       = (scrnum == 2'd1);
        step_end      = (tick_reg == '0) && (rem_reg == 2'd0);
        last_expiring = (state_reg != IDLE) && step_end && (step_reg == 2'd2);
        // The cycle the final step expires behaves like IDLE for new requests,
        // so a request there starts a fresh effect with no BGM cycle between.
        take_idle_req = (state_reg == IDLE) || last_expiring;

`ifdef SFX_PREEMPT_EN
        start_miss = miss_req;
        start_hit  = hit_req && !miss_req && ((state_reg != MISS) || last_expiring);
`else
        start_miss = miss_req && take_idle_req;
        start_hit  = hit_req && !miss_req && take_idle_req;
`endif

        if (!enabled) begin
            state_next = IDLE;
            step_next  = 2'd0;
            tick_next  = '0;
            rem_next   = 2'd0;
        end else if (start_miss) begin
            state_next = MISS;
            step_next  = 2'd0;
            tick_next  = TICK_RELOAD;
            rem_next   = step_len_m1(MISS, 2'd0);
        end else if (start_hit) begin
            state_next = HIT;
            step_next  = 2'd0;
            tick_next  = TICK_RELOAD;
            rem_next   = step_len_m1(HIT, 2'd0);
        end else if (state_reg != IDLE) begin
            if (tick_reg != '0) begin
                tick_next = tick_reg - 1'b1;
            end else if (rem_reg != 2'd0) begin
                rem_next  = rem_reg - 2'd1;
                tick_next = TICK_RELOAD;
            end else if (step_reg == 2'd2) begin
                state_next = IDLE;
                step_next  = 2'd0;
                tick_next  = '0;
                rem_next   = 2'd0;
            end else begin
                step_next = step_reg + 2'd1;
                tick_next = TICK_RELOAD;
                rem_next  = step_len_m1(state_reg, step_reg + 2'd1);
            end
        end

        if (state_next == IDLE) begin
            scale_next  = enabled ? bgm_scale : 7'd0;
            active_next = 1'b0;
        end else begin
            scale_next  = step_code(state_next, step_next);
            active_next = 1'b1;
        end
    end

    // State, counters and outputs; reset aborts any effect immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            step_reg   <= 2'd0;
            tick_reg   <= '0;
            rem_reg    <= 2'd0;
            scale_reg  <= 7'd0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            step_reg   <= step_next;
            tick_reg   <= tick_next;
            rem_reg    <= rem_next;
            scale_reg  <= scale_next;
            active_reg <= active_next;
        end
    end

    assign scale      = scale_reg;
    assign sfx_active = active_reg;

endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: directed bench for sfx_arbiter with TICK_CYCLES = 10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sfx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] scrnum;
    logic [6:0] bgm_scale;
    logic       hit_req;
    logic       miss_req;
    logic [6:0] scale;
    logic       sfx_active;

    int vectors    = 0;
    int miscompares = 0;

    sfx_arbiter #(.TICK_CYCLES(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .scrnum     (scrnum),
        .bgm_scale  (bgm_scale),
        .hit_req    (hit_req),
        .miss_req   (miss_req),
        .scale      (scale),
        .sfx_active (sfx_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check scale/sfx_active for n consecutive cycles, starting at the current falling edge.
    task automatic run(input string tag, input int code, input int n, input int act);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s scale[%0d]", tag, i), int'(scale), code);
            check($sformatf("%s active[%0d]", tag, i), int'(sfx_active), act);
            @(negedge clk);
        end
        $display("step %s: %0d cycles of scale=%0d active=%0d checked", tag, n, code, act);
    endtask

    // One-cycle request pulse; returns at the first cycle after the sampling edge.
    task automatic pulse(input logic h, input logic m);
        hit_req  = h;
        miss_req = m;
        @(negedge clk);
        hit_req  = 1'b0;
        miss_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; scrnum = 2'd0; bgm_scale = 7'd61; hit_req = 1'b0; miss_req = 1'b0;
        repeat (3) @(negedge clk);
        run("reset", 0, 2, 0);

        // Release reset with the game screen selected: pass-through next cycle.
        rst = 1'b0; scrnum = 2'd1;
        run("release", 0, 1, 0);
        run("bgm", 61, 3, 0);

        // Hit effect then back to BGM, followed by a pass-through latency check.
        pulse(1'b1, 1'b0);
        run("hit s0", 36, 10, 1);
        run("hit s1", 31, 10, 1);
        run("hit s2", 23, 20, 1);
        run("hit end", 61, 1, 0);
        bgm_scale = 7'd50;
        run("bgm lag", 61, 1, 0);
        run("bgm new", 50, 2, 0);

        // Simultaneous requests: miss wins; a hit during MISS is ignored in both builds.
        pulse(1'b1, 1'b1);
        run("both s0a", 82, 5, 1);
        pulse(1'b1, 1'b0);
        run("both s0b", 82, 14, 1);
        run("both gap", 0, 10, 1);
        run("both s2", 92, 30, 1);
        run("both end", 50, 2, 0);

        // Miss requested 15 cycles into a hit.
        pulse(1'b1, 1'b0);
        run("pre s0", 36, 10, 1);
        run("pre s1", 31, 4, 1);
        pulse(1'b0, 1'b1);
`ifdef SFX_PREEMPT_EN
        run("pre miss s0", 82, 20, 1);
        run("pre miss gap", 0, 10, 1);
        run("pre miss s2", 92, 30, 1);
`else
        run("pre s1 rest", 31, 5, 1);
        run("pre s2", 23, 20, 1);
`endif
        run("pre end", 50, 2, 0);

        // Request on the exact cycle the last step expires restarts with no BGM cycle.
        pulse(1'b1, 1'b0);
        run("edge s0", 36, 10, 1);
        run("edge s1", 31, 10, 1);
        run("edge s2", 23, 19, 1);
        pulse(1'b1, 1'b0);
        run("edge re s0", 36, 10, 1);
        run("edge re s1", 31, 10, 1);
        run("edge re s2", 23, 20, 1);
        run("edge end", 50, 1, 0);

        // Screen change mid-MISS aborts and mutes; requests are ignored off-screen.
        pulse(1'b0, 1'b1);
        run("scr s0", 82, 20, 1);
        run("scr gap", 0, 5, 1);
        scrnum = 2'd2;
        @(negedge clk);
        run("scr off", 0, 2, 0);
        pulse(1'b1, 1'b1);
        run("scr ign", 0, 12, 0);
        scrnum = 2'd1;
        @(negedge clk);
        run("scr back", 50, 2, 0);

        // Reset mid-HIT aborts; the next hit starts from step 0.
        pulse(1'b1, 1'b0);
        run("rst s0", 36, 3, 1);
        rst = 1'b1;
        @(negedge clk);
        run("rst mid", 0, 1, 0);
        rst = 1'b0;
        @(negedge clk);
        run("rst rel", 50, 1, 0);
        pulse(1'b1, 1'b0);
        run("rst hit s0", 36, 10, 1);
        run("rst hit s1", 31, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Shares the single tone generator between the background-music sequencer and two short game sound effects (hit and miss).
- It passes the BGM scale code through while idle.
- On a request it plays a fixed, tick-timed effect sequence in place of the BGM, then returns to the BGM.
- It sits between the BGM sequencer's `scale` output and the tone generator's period input, and is driven by the judgement logic's hit/miss pulses.

## Interface

Parameters:
- `TICK_CYCLES`, default 10_000_000: clock cycles per effect tick (0.1 s at 100 MHz).

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  synchronous, active-high reset
- `scrnum`  in  2  current screen; the arbiter is enabled only when `scrnum == 1`
- `bgm_scale`  in  7  scale code from the BGM sequencer; 0 = rest
- `hit_req`  in  1  single-cycle request for the hit effect
- `miss_req`  in  1  single-cycle request for the miss effect
- `scale`  out  7  registered scale code to the tone generator; 0 = silence
- `sfx_active`  out  1  registered; high while an effect is sounding

## Operation

States:
- IDLE
- HIT
- MISS

Each effect state walks a fixed step list. A step is a pair {scale code, duration in ticks}.
- HIT: {36,1}, {31,1}, {23,2}. Three steps, 4 ticks total.
- MISS: {82,2}, {0,1}, {92,3}. Three steps, 6 ticks total. The 0 step is a silent gap.

Internal counters:
- Step index: 2 bits.
- Tick counter: counts `TICK_CYCLES-1` down to 0.
- Remaining-ticks counter: 2 bits, loaded with step duration − 1.

Transitions:
- IDLE → MISS on `miss_req`. Otherwise IDLE → HIT on `hit_req`. Miss has priority when both requests arrive in the same cycle, and the hit is dropped.
- On entry to an effect, the step index is set to 0 and both counters are reloaded.
- At the end of a step (tick counter 0 and remaining ticks 0), advance to the next step. After the last step, return to IDLE.
- Request while in HIT:
  - `miss_req` preempts the hit and restarts in MISS step 0.
  - `hit_req` restarts HIT at step 0.
- Request while in MISS:
  - `miss_req` restarts MISS at step 0.
  - `hit_req` is ignored.
- If `scrnum != 1`, force IDLE, clear the counters and ignore all requests.

Output values:
- `scale` in IDLE: `bgm_scale` when `scrnum == 1`, otherwise 0.
- `scale` in an effect state: the current step's code.
- `sfx_active`: 1 in HIT or MISS, 0 in IDLE.
- The BGM sequencer keeps running while an effect plays. The arbiter never stalls it, so the BGM resumes wherever it has advanced to.

## Timing

- Reset: state IDLE, `scale = 0`, `sfx_active = 0`, all counters 0. Reset has priority over every other input. Reset asserted mid-effect aborts the effect, and no residual tone remains on the cycle after reset.
- Pass-through latency: `bgm_scale` appears on `scale` one clock later.
- Request latency: a request sampled at edge N drives the first step code on `scale`, and `sfx_active = 1`, after edge N.
- Each step holds exactly duration × `TICK_CYCLES` cycles. The tick phase is restarted on every effect entry or restart and is not aligned to the BGM's 0.1 s tick.
- End of effect: the cycle after the final step expires, `scale` returns to the current `bgm_scale` and `sfx_active` = 0.
- Total effect length from first effect cycle to first BGM cycle: HIT 4 × `TICK_CYCLES` cycles, MISS 6 × `TICK_CYCLES` cycles.
- A request arriving on the exact cycle the last step expires is taken as a new entry. It takes priority over the return to IDLE, with no BGM cycle in between.
- `scrnum` leaving 1 mid-effect: `scale` = 0 and `sfx_active` = 0 on the next cycle.

## Configuration

`SFX_PREEMPT_EN`:
- Defined: preempt and restart rules as described in Operation.
- Undefined: any request while in HIT or MISS is ignored, and every effect plays to completion. The IDLE priority rule (miss over hit) still applies.

## Test plan

All scenarios use `TICK_CYCLES = 10`.
- Reset and pass-through: hold `rst`, then release with `scrnum = 1` and `bgm_scale = 61` → `scale = 0` during reset, then 61 one cycle after release; `sfx_active = 0` throughout.
- Hit sequence: pulse `hit_req` with `bgm_scale = 61` → `scale` reads 36 for 10 cycles, 31 for 10, 23 for 20, then 61. `sfx_active` is high for exactly 40 cycles.
- Simultaneous requests: pulse `hit_req` and `miss_req` together → `scale` reads 82 ×20, 0 ×10, 92 ×30, then BGM. No hit codes appear.
- Preemption with `SFX_PREEMPT_EN` defined: `hit_req`, then `miss_req` 15 cycles later → `scale` 36 ×10, 31 ×5, then the full 60-cycle MISS sequence. A `hit_req` during MISS leaves the sequence unchanged.
- Preemption with `SFX_PREEMPT_EN` undefined: the same stimulus → full 40-cycle HIT, then BGM. The miss is dropped.
- Screen and reset abort: mid-MISS, set `scrnum = 2` → `scale = 0` and `sfx_active = 0` next cycle, and requests are ignored. Repeat with `rst` mid-HIT → outputs 0 next cycle; after release, a `hit_req` plays from step 0 (36).
